int_source_ctrl: RTL and testbench
==================================

# int_source_ctrl

Collects the SoC's raw interrupt lines, synchronises them, latches pending state and presents one enabled source at a time as a one-hot vector on the core's `int_flag_i` input. It sits directly upstream of the core's interrupt control logic. It exposes a small memory-mapped register window so trap handlers can enable sources, pick the trigger type, and acknowledge sources by write-1-to-clear.

## Interface
Parameters:
- `INT_NUM`, default 14: number of interrupt sources; must equal the width of the core's `INT_BUS`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset; active-low and synchronous, sampled on the rising edge of `clk`.
- `irq_i`  in  INT_NUM  raw asynchronous interrupt lines.
- `bus_req_i`  in  1  register access request (single cycle).
- `bus_we_i`  in  1  1 = write, 0 = read.
- `bus_addr_i`  in  4  byte address; bits [3:2] select the register, bits [1:0] are ignored.
- `bus_wdata_i`  in  32  write data.
- `bus_rdata_o`  out  32  read data, registered.
- `bus_ack_o`  out  1  access complete, exactly one cycle after `bus_req_i`.
- `int_flag_o`  out  INT_NUM  one-hot presented interrupt; connects to `int_flag_i` of the core.

## Operation
Synchronisation:
- Each `irq_i` bit passes through a 2-flop synchroniser (`s1`, `s2`), then a history flop `s3`.
- Rising edge detect: `rise = s2 & ~s3`.

Registers (bits above `INT_NUM-1` read 0 and ignore writes):
- 0x0 PENDING: read; write-1-to-clear.
- 0x4 ENABLE: read/write; reset value 0.
- 0x8 TRIGGER: read/write; 1 = edge, 0 = level; reset value 0.
- 0xC ACTIVE: read-only; returns the current `int_flag_o`. Writes are ignored.

Pending update, per bit i:
- Level source: `pend[i] <= s2[i]`. W1C has no effect.
- Edge source: set on `rise[i]`; cleared by W1C. Set and clear in the same cycle → set wins.
- A TRIGGER write takes effect for pending evaluation from the next cycle.

Presentation FSM:
- IDLE: `int_flag_o` = 0.
  - If `pend & ENABLE` ≠ 0, latch `sel` = one-hot of the lowest set index and go to PRESENT.
- PRESENT: `int_flag_o` = `sel`, held stable.
  - Go back to IDLE when `(pend & ENABLE & sel) == 0`, i.e. the source was acknowledged or disabled.
  - Higher-priority arrivals never preempt a presented source.
- IDLE always lasts at least one cycle between two presentations. This guarantees `int_flag_o` drops to 0 for at least one cycle, so the downstream can see that the source changed.

Bus:
- A read returns the selected register value sampled in the request cycle.
- Writes update state at the same clock edge as the request.
- `bus_ack_o` is high for one cycle following every `bus_req_i`.
- Back-to-back requests on consecutive cycles are legal.
- Unmapped addresses cannot occur, since 2 select bits cover all 4 registers.

## Timing
Reset values (`rst_n` low at an edge):
- `s1`, `s2`, `s3`, pending, ENABLE, TRIGGER, `sel` all 0.
- `int_flag_o` = 0, `bus_rdata_o` = 0, `bus_ack_o` = 0.
- FSM state = IDLE.
- Reset asserted mid-presentation drops `int_flag_o` at the next edge.

Latency, with `irq_i` rising before edge k and the source enabled:
- `s1` = 1 after edge k.
- `s2` = 1 after edge k+1.
- `pend` = 1 after edge k+2.
- `int_flag_o` = 1 after edge k+3.

Acknowledge:
- W1C of the presented bit at edge m → `int_flag_o` = 0 after edge m+1.
- The next source can be presented after edge m+2 at the earliest.

Bus:
- Request at edge n → `bus_ack_o` and `bus_rdata_o` valid after edge n, for one cycle.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with `irq_i` = all ones → `int_flag_o` = 0, ENABLE reads 0. After release with nothing enabled, `int_flag_o` stays 0.
- Edge latency: ENABLE = 0x3FFF, TRIGGER = 0x3FFF; pulse `irq_i[5]` high for 1 cycle at edge k → PENDING reads 0x20; `int_flag_o` = 0x0020 from edge k+3 and is held. Writing 0x20 to PENDING → `int_flag_o` = 0 after 1 cycle.
- Priority and no preemption: edge mode, bits 7 and 3 pending simultaneously → present 0x0008. Bit 1 rises while 0x0008 is presented → output unchanged. After W1C of bit 3: one cycle at 0, then 0x0002, then 0x0080 after bit 1 is cleared.
- Level source: TRIGGER = 0, ENABLE bit 10, `irq_i[10]` held high → `int_flag_o` = 0x0400. W1C of 0x400 has no effect; dropping `irq_i[10]` → `int_flag_o` = 0 three cycles later.
- Set/clear collision: edge bit 2 pending; W1C 0x4 in the same cycle as a new rising edge on bit 2 → PENDING bit 2 remains 1.
- Disable while presented: present 0x0001, then write ENABLE = 0 → `int_flag_o` = 0 next cycle. PENDING bit 0 is still 1; re-enabling re-presents 0x0001.

Source files
------------

// File: rtl/int_source_ctrl_if.sv
// -----------------------------------------------------------------------------
// int_source_ctrl_if
//
// Register-access bus between a requester (trap handler side) and
// int_source_ctrl. Single-cycle request, acknowledge one cycle later.
//
// Signals (suffixes are from the controller's point of view):
//   bus_req_i    request strobe, one cycle per access
//   bus_we_i     1 = write, 0 = read
//   bus_addr_i   byte address, [3:2] selects the register, [1:0] ignored
//   bus_wdata_i  write data
//   bus_rdata_o  registered read data
//   bus_ack_o    access complete, one cycle after the request
//
// Modports:
//   master  requester side, drives the request fields
//   slave   controller side, returns rdata/ack
// -----------------------------------------------------------------------------
interface int_source_ctrl_if;

    logic        bus_req_i;
    logic        bus_we_i;
    logic [3:0]  bus_addr_i;
    logic [31:0] bus_wdata_i;
    logic [31:0] bus_rdata_o;
    logic        bus_ack_o;

    modport master (
        output bus_req_i,
        output bus_we_i,
        output bus_addr_i,
        output bus_wdata_i,
        input  bus_rdata_o,
        input  bus_ack_o
    );

    modport slave (
        input  bus_req_i,
        input  bus_we_i,
        input  bus_addr_i,
        input  bus_wdata_i,
        output bus_rdata_o,
        output bus_ack_o
    );

endinterface

// File: rtl/int_source_ctrl.sv
// -----------------------------------------------------------------------------
// int_source_ctrl
//
// Collects raw interrupt lines, synchronises them, keeps per-source pending
// state and presents exactly one enabled source at a time as a one-hot vector
// to the core's interrupt input. A small register window lets software enable
// sources, choose edge/level triggering and acknowledge edge sources (W1C).
//
// Parameters:
//   INT_NUM      number of interrupt sources (1..32), width of the core INT_BUS
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   irq_i        raw asynchronous interrupt lines
//   bus          register access bus (slave side)
//   int_flag_o   one-hot presented interrupt, 0 when nothing is presented
//
// Register map (bits above INT_NUM-1 read 0, writes ignored):
//   0x0 PENDING  read, write-1-to-clear (edge sources only)
//   0x4 ENABLE   read/write
//   0x8 TRIGGER  read/write, 1 = edge, 0 = level
//   0xC ACTIVE   read-only, current int_flag_o
// -----------------------------------------------------------------------------
module int_source_ctrl #(
    parameter int unsigned INT_NUM = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INT_NUM-1:0] irq_i,
    int_source_ctrl_if.slave   bus,
    output logic [INT_NUM-1:0] int_flag_o
);

    // Register select values (bus_addr_i[3:2]).
    localparam logic [1:0] RegPending = 2'd0;
    localparam logic [1:0] RegEnable  = 2'd1;
    localparam logic [1:0] RegTrigger = 2'd2;
    localparam logic [1:0] RegActive  = 2'd3;

    typedef enum logic [0:0] {
        StIdle,
        StPresent
    } state_e;

    // -------------------------------------------------------------------------
    // Signals
    // -------------------------------------------------------------------------
    logic [INT_NUM-1:0] s1_q, s2_q, s3_q;
    logic [INT_NUM-1:0] rise;

    logic [INT_NUM-1:0] pend_q, pend_d;
    logic [INT_NUM-1:0] en_q, en_d;
    logic [INT_NUM-1:0] trig_q, trig_d;

    logic [INT_NUM-1:0] sel_q, sel_d;
    logic [INT_NUM-1:0] flag_q, flag_d;
    state_e             state_q, state_d;

    logic [31:0]        rdata_q, rdata_d;
    logic               ack_q, ack_d;

    logic [1:0]         reg_sel;
    logic               wr_pend, wr_en, wr_trig;
    logic [INT_NUM-1:0] wdata_trunc;
    logic [INT_NUM-1:0] w1c;
    logic [INT_NUM-1:0] candidates;
    logic [INT_NUM-1:0] lowest;
    logic [31:0]        rd_val;
    logic               unused_bus_bits;

    // -------------------------------------------------------------------------
    // Bus decode
    // -------------------------------------------------------------------------
    assign reg_sel     = bus.bus_addr_i[3:2];
    assign wdata_trunc = bus.bus_wdata_i[INT_NUM-1:0];
    assign wr_pend     = bus.bus_req_i & bus.bus_we_i & (reg_sel == RegPending);
    assign wr_en       = bus.bus_req_i & bus.bus_we_i & (reg_sel == RegEnable);
    assign wr_trig     = bus.bus_req_i & bus.bus_we_i & (reg_sel == RegTrigger);

    // Address byte-lane bits and upper write-data bits carry no meaning here.
    assign unused_bus_bits = ^{bus.bus_addr_i[1:0], bus.bus_wdata_i};

    // -------------------------------------------------------------------------
    // Pending / enable / trigger next state
    // -------------------------------------------------------------------------
    assign rise = s2_q & ~s3_q;
    assign w1c  = wr_pend ? wdata_trunc : '0;

    always_comb begin
        // Edge sources: set on a synchronised rising edge, cleared by W1C, set
        // wins a same-cycle collision. Level sources simply follow s2.
        // trig_q is the registered value, so a TRIGGER write only affects this
        // evaluation from the following cycle.
        pend_d = (trig_q & ((pend_q & ~w1c) | rise)) | (~trig_q & s2_q);
        en_d   = wr_en   ? wdata_trunc : en_q;
        trig_d = wr_trig ? wdata_trunc : trig_q;
    end

    // -------------------------------------------------------------------------
    // Bus response
    // -------------------------------------------------------------------------
    always_comb begin
        rd_val = '0;
        unique case (reg_sel)
            RegPending: rd_val[INT_NUM-1:0] = pend_q;
            RegEnable:  rd_val[INT_NUM-1:0] = en_q;
            RegTrigger: rd_val[INT_NUM-1:0] = trig_q;
            RegActive:  rd_val[INT_NUM-1:0] = flag_q;
            default:    rd_val              = '0;
        endcase
        rdata_d = (bus.bus_req_i && !bus.bus_we_i) ? rd_val : '0;
        ack_d   = bus.bus_req_i;
    end

    // -------------------------------------------------------------------------
    // Presentation FSM next state
    // -------------------------------------------------------------------------
    assign candidates = pend_q & en_q;
    // Isolate the lowest set bit (two's complement trick): lowest index wins.
    assign lowest     = candidates & (-candidates);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        flag_d  = flag_q;
        unique case (state_q)
            StIdle: begin
                if (candidates != '0) begin
                    state_d = StPresent;
                    sel_d   = lowest;
                    flag_d  = lowest;
                end else begin
                    flag_d  = '0;
                end
            end
            StPresent: begin
                // Only acknowledge or disable of the presented source ends the
                // presentation; newer, higher-priority arrivals wait. Passing
                // through StIdle forces the output to 0 for at least one cycle.
                if ((candidates & sel_q) == '0) begin
                    state_d = StIdle;
                    sel_d   = '0;
                    flag_d  = '0;
                end else begin
                    flag_d  = sel_q;
                end
            end
            default: begin
                state_d = StIdle;
                sel_d   = '0;
                flag_d  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            pend_q  <= '0;
            en_q    <= '0;
            trig_q  <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            s1_q    <= irq_i;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pend_q  <= pend_d;
            en_q    <= en_d;
            trig_q  <= trig_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            flag_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            flag_q  <= flag_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign int_flag_o      = flag_q;
    assign bus.bus_rdata_o = rdata_q;
    assign bus.bus_ack_o   = ack_q;

endmodule

// File: tb/tb_int_source_ctrl.sv
module tb_int_source_ctrl;

    localparam int N = 14;
    localparam logic [13:0] AllSrc = 14'h3FFF;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  irq;
    logic [N-1:0]  int_flag;

    int_source_ctrl_if bus_if ();

    int_source_ctrl #(
        .INT_NUM (N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_i      (irq),
        .bus        (bus_if.slave),
        .int_flag_o (int_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One bus access; returns the read data captured after the request edge.
    task automatic bus_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd);
        bus_if.bus_req_i   = 1'b1;
        bus_if.bus_we_i    = we;
        bus_if.bus_addr_i  = addr;
        bus_if.bus_wdata_i = wd;
        tick();
        check("bus_ack", {31'b0, bus_if.bus_ack_o}, 32'd1);
        rd = bus_if.bus_rdata_o;
        bus_if.bus_req_i   = 1'b0;
        bus_if.bus_we_i    = 1'b0;
    endtask

    task automatic bus_wr(input logic [3:0] addr, input logic [31:0] wd);
        logic [31:0] dummy;
        bus_xfer(1'b1, addr, wd, dummy);
    endtask

    task automatic bus_rd(input logic [3:0] addr, output logic [31:0] rd);
        bus_xfer(1'b0, addr, 32'h0, rd);
    endtask

    task automatic pulse(input logic [N-1:0] mask);
        irq = irq | mask;
        tick();
        irq = irq & ~mask;
    endtask

    // ------------------------------------------------------------------------
    // Reference model: interrupt lines seen through a 2-sample delay, pending
    // bits, and the presented source kept as an index (-1 = nothing shown).
    // ------------------------------------------------------------------------
    bit [N-1:0]  m_hist [3];   // [0] newest sample ... [2] oldest
    bit [N-1:0]  m_pend, m_en, m_trig;
    int          m_pres;
    bit          m_ack;
    bit          m_rd;
    bit [31:0]   m_rdata;

    function automatic bit [N-1:0] onehot(input int idx);
        bit [N-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic model_edge(input bit rst, input bit [N-1:0] lines, input bit req,
                              input bit we, input bit [3:0] addr, input bit [31:0] wd);
        bit [N-1:0] n_pend;
        int         n_pres;
        int         reg_no;
        bit [31:0]  rv;
        if (!rst) begin
            for (int j = 0; j < 3; j++) m_hist[j] = '0;
            m_pend = '0; m_en = '0; m_trig = '0; m_pres = -1;
            m_ack = 0; m_rd = 0; m_rdata = '0;
            return;
        end
        reg_no = int'(addr) / 4;
        rv = 0;
        if (reg_no == 0) rv = 32'(m_pend);
        if (reg_no == 1) rv = 32'(m_en);
        if (reg_no == 2) rv = 32'(m_trig);
        if (reg_no == 3) rv = 32'(onehot(m_pres));
        for (int i = 0; i < N; i++) begin
            if (!m_trig[i]) begin
                n_pend[i] = m_hist[1][i];
            end else begin
                bit cleared, rose;
                cleared = req && we && reg_no == 0 && wd[i];
                rose    = m_hist[1][i] && !m_hist[2][i];
                n_pend[i] = (m_pend[i] && !cleared) || rose;
            end
        end
        if (m_pres < 0) begin
            n_pres = -1;
            for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_en[i]) n_pres = i;
        end else if (m_pend[m_pres] && m_en[m_pres]) begin
            n_pres = m_pres;
        end else begin
            n_pres = -1;
        end
        if (req && we && reg_no == 1) m_en   = wd[N-1:0];
        if (req && we && reg_no == 2) m_trig = wd[N-1:0];
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = lines;
        m_pend  = n_pend;
        m_pres  = n_pres;
        m_ack   = req;
        m_rd    = req && !we;
        m_rdata = rv;
    endtask

    // ------------------------------------------------------------------------
    // Register-access vector table
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [31:0] rd;
        bit [N-1:0]  flips;

        vecs[0]  = '{we: 1'b0, addr: 4'h4, wdata: 32'h0,         exp: 32'h0};
        vecs[1]  = '{we: 1'b0, addr: 4'h8, wdata: 32'h0,         exp: 32'h0};
        vecs[2]  = '{we: 1'b1, addr: 4'h4, wdata: 32'hFFFF_FFFF, exp: 32'h0};
        vecs[3]  = '{we: 1'b0, addr: 4'h4, wdata: 32'h0,         exp: 32'h3FFF};
        vecs[4]  = '{we: 1'b1, addr: 4'h8, wdata: 32'hA5A5_A5A5, exp: 32'h0};
        vecs[5]  = '{we: 1'b0, addr: 4'h8, wdata: 32'h0,         exp: 32'h25A5};
        vecs[6]  = '{we: 1'b1, addr: 4'hC, wdata: 32'hFFFF_FFFF, exp: 32'h0};
        vecs[7]  = '{we: 1'b0, addr: 4'hC, wdata: 32'h0,         exp: 32'h0};
        vecs[8]  = '{we: 1'b0, addr: 4'h0, wdata: 32'h0,         exp: 32'h0};
        vecs[9]  = '{we: 1'b0, addr: 4'h5, wdata: 32'h0,         exp: 32'h3FFF};
        vecs[10] = '{we: 1'b1, addr: 4'h6, wdata: 32'h0000_1234, exp: 32'h0};
        vecs[11] = '{we: 1'b0, addr: 4'h7, wdata: 32'h0,         exp: 32'h1234};
        vecs[12] = '{we: 1'b0, addr: 4'hB, wdata: 32'h0,         exp: 32'h25A5};

        bus_if.bus_req_i   = 1'b0;
        bus_if.bus_we_i    = 1'b0;
        bus_if.bus_addr_i  = 4'h0;
        bus_if.bus_wdata_i = 32'h0;
        m_pres = -1;

        // ---------------- Reset with all lines high ----------------
        rst_n = 1'b0;
        irq   = AllSrc;
        ticks(2);
        check("reset_flag", 32'(int_flag), 32'h0);
        check("reset_ack", {31'b0, bus_if.bus_ack_o}, 32'h0);
        check("reset_rdata", bus_if.bus_rdata_o, 32'h0);
        rst_n = 1'b1;
        bus_rd(4'h4, rd);
        check("reset_enable", rd, 32'h0);
        ticks(4);
        check("idle_after_reset_flag", 32'(int_flag), 32'h0);
        bus_rd(4'h0, rd);
        check("level_pending_all", rd, 32'h3FFF);
        irq = '0;
        ticks(4);
        bus_rd(4'h0, rd);
        check("level_pending_none", rd, 32'h0);

        // ---------------- Register table ----------------
        for (int v = 0; v < 13; v++) begin
            bus_xfer(vecs[v].we, vecs[v].addr, vecs[v].wdata, rd);
            if (!vecs[v].we) check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp);
        end

        // ---------------- Edge latency ----------------
        bus_wr(4'h4, 32'h3FFF);
        bus_wr(4'h8, 32'h3FFF);
        pulse(14'h0020);                       // edge k
        check("lat_k0", 32'(int_flag), 32'h0);
        tick();
        check("lat_k1", 32'(int_flag), 32'h0);
        tick();
        check("lat_k2", 32'(int_flag), 32'h0);
        tick();
        check("lat_k3", 32'(int_flag), 32'h20);
        bus_rd(4'h0, rd);
        check("lat_pending", rd, 32'h20);
        check("lat_held", 32'(int_flag), 32'h20);
        bus_wr(4'h0, 32'h20);                  // edge m
        check("ack_m0", 32'(int_flag), 32'h20);
        tick();
        check("ack_m1", 32'(int_flag), 32'h0);

        // ---------------- Priority, no preemption ----------------
        pulse(14'h0088);
        ticks(3);
        check("prio_lowest", 32'(int_flag), 32'h08);
        pulse(14'h0002);
        ticks(3);
        check("prio_no_preempt", 32'(int_flag), 32'h08);
        bus_rd(4'h0, rd);
        check("prio_pending", rd, 32'h8A);
        bus_wr(4'h0, 32'h08);
        check("prio_ack3_m0", 32'(int_flag), 32'h08);
        tick();
        check("prio_gap1", 32'(int_flag), 32'h0);
        tick();
        check("prio_next1", 32'(int_flag), 32'h02);
        bus_wr(4'h0, 32'h02);
        tick();
        check("prio_gap2", 32'(int_flag), 32'h0);
        tick();
        check("prio_next7", 32'(int_flag), 32'h80);
        bus_wr(4'h0, 32'h80);
        ticks(2);
        check("prio_done", 32'(int_flag), 32'h0);

        // ---------------- Level source ----------------
        bus_wr(4'h8, 32'h0);
        bus_wr(4'h4, 32'h400);
        irq[10] = 1'b1;
        ticks(4);
        check("level_present", 32'(int_flag), 32'h400);
        bus_wr(4'h0, 32'h400);
        ticks(2);
        check("level_w1c_ignored", 32'(int_flag), 32'h400);
        bus_rd(4'h0, rd);
        check("level_pending", rd, 32'h400);
        irq[10] = 1'b0;
        ticks(3);
        check("level_drop_k2", 32'(int_flag), 32'h400);
        tick();
        check("level_drop_k3", 32'(int_flag), 32'h0);

        // ---------------- Set/clear collision ----------------
        bus_wr(4'h4, 32'h0);
        bus_wr(4'h8, 32'h3FFF);
        pulse(14'h0004);
        ticks(3);
        bus_rd(4'h0, rd);
        check("coll_pre", rd, 32'h4);
        irq[2] = 1'b1;
        ticks(2);
        bus_wr(4'h0, 32'h4);                   // same edge as the synchronised rise
        irq[2] = 1'b0;
        bus_rd(4'h0, rd);
        check("coll_set_wins", rd, 32'h4);
        ticks(3);
        bus_wr(4'h0, 32'h4);
        bus_rd(4'h0, rd);
        check("coll_plain_clear", rd, 32'h0);

        // ---------------- Disable while presented ----------------
        pulse(14'h0001);
        ticks(3);
        bus_wr(4'h4, 32'h1);
        tick();
        check("dis_present", 32'(int_flag), 32'h1);
        bus_wr(4'h4, 32'h0);
        check("dis_m0", 32'(int_flag), 32'h1);
        tick();
        check("dis_m1", 32'(int_flag), 32'h0);
        bus_rd(4'h0, rd);
        check("dis_pending_kept", rd, 32'h1);
        bus_wr(4'h4, 32'h1);
        tick();
        check("dis_re_present", 32'(int_flag), 32'h1);
        bus_rd(4'hC, rd);
        check("active_reg", rd, 32'h1);

        // ---------------- Reset mid-presentation ----------------
        rst_n = 1'b0;
        tick();
        check("reset_mid_present", 32'(int_flag), 32'h0);

        // ---------------- Randomised run against the model ----------------
        model_edge(1'b0, irq, 1'b0, 1'b0, 4'h0, 32'h0);
        tick();
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            flips = N'($urandom & $urandom & $urandom);
            irq   = irq ^ flips;
            bus_if.bus_req_i   = ($urandom_range(0, 2) == 0);
            bus_if.bus_we_i    = $urandom_range(0, 1) == 1;
            bus_if.bus_addr_i  = 4'($urandom_range(0, 15));
            bus_if.bus_wdata_i = $urandom;
            model_edge(rst_n, irq, bus_if.bus_req_i, bus_if.bus_we_i, bus_if.bus_addr_i,
                       bus_if.bus_wdata_i);
            tick();
            check("rand_flag", 32'(int_flag), 32'(onehot(m_pres)));
            check("rand_ack", {31'b0, bus_if.bus_ack_o}, {31'b0, m_ack});
            if (m_rd) check("rand_rdata", bus_if.bus_rdata_o, m_rdata);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
